// File: rtl/lut_ram_wr_ctrl_pkg.sv
// Shared types for the LUT RAM write path: the address and data word widths.
package lut_ram_wr_ctrl_pkg;
  typedef logic [4:0]  lut_addr_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/lut_ram_wr_ctrl_if.sv
// Valid/ready write-request channel from one requester into the LUT RAM write controller.
interface lut_ram_wr_ctrl_if;
  import lut_ram_wr_ctrl_pkg::*;

  logic      valid;
  logic      ready;
  lut_addr_t addr;
  word_t     data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/lut_ram_wr_ctrl.sv
// Round-robin write-port controller for the LUT RAM; two requesters share one registered write port.
// Optional post-reset sweep of every entry to INIT_VALUE is enabled by defining LUT_RAM_WR_CTRL_INIT_EN.
module lut_ram_wr_ctrl
  import lut_ram_wr_ctrl_pkg::*;
#(
  parameter int    DEPTH      = 2**$bits(lut_addr_t),
  parameter word_t INIT_VALUE = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  lut_ram_wr_ctrl_if.slave         req0,
  lut_ram_wr_ctrl_if.slave         req1,
  output logic                     ram_wr_en,
  output lut_addr_t                ram_wr_addr,
  output word_t                    ram_wr_data,
  output logic                     init_busy,
  output logic                     last_grant
);

  logic      wr_en_q;
  lut_addr_t addr_q;
  word_t     data_q;
  logic      rr;
  logic      run;
  logic      gnt0;
  logic      gnt1;

`ifdef LUT_RAM_WR_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t    state;
  lut_addr_t init_cnt;

  assign init_busy = (state == ST_INIT);
`else
  logic unused_cfg;

  assign init_busy  = 1'b0;
  assign unused_cfg = ^{INIT_VALUE, DEPTH};
`endif

  assign run = !init_busy;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run) begin
      if (req0.valid && (!req1.valid || !rr)) gnt0 = 1'b1;
      else if (req1.valid)                    gnt1 = 1'b1;
    end
  end

  assign req0.ready = gnt0;
  assign req1.ready = gnt1;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rr         <= 1'b0;
      last_grant <= 1'b0;
`ifdef LUT_RAM_WR_CTRL_INIT_EN
      state      <= ST_INIT;
      init_cnt   <= '0;
`endif
    end else begin
      wr_en_q <= gnt0 | gnt1;
      if (gnt0) begin
        addr_q     <= req0.addr;
        data_q     <= req0.data;
        rr         <= 1'b1;
        last_grant <= 1'b0;
      end else if (gnt1) begin
        addr_q     <= req1.addr;
        data_q     <= req1.data;
        rr         <= 1'b0;
        last_grant <= 1'b1;
      end
`ifdef LUT_RAM_WR_CTRL_INIT_EN
      // Track the sweep in the hold registers so the port idles on the last swept entry.
      if (state == ST_INIT) begin
        addr_q   <= init_cnt;
        data_q   <= INIT_VALUE;
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == lut_addr_t'(DEPTH - 1)) state <= ST_RUN;
      end
`endif
    end
  end

  // The sweep drives the port directly from init_cnt; rst masks any pending write.
`ifdef LUT_RAM_WR_CTRL_INIT_EN
  assign ram_wr_en   = !rst && (wr_en_q || init_busy);
  assign ram_wr_addr = init_busy ? init_cnt   : addr_q;
  assign ram_wr_data = init_busy ? INIT_VALUE : data_q;
`else
  assign ram_wr_en   = !rst && wr_en_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = data_q;
`endif

endmodule

// File: doc/lut_ram_wr_ctrl.md
# lut_ram_wr_ctrl

Write-port controller for the single-write-port LUT RAM. It shares the RAM write port between two requesters using round-robin arbitration with a valid/ready handshake. It registers the winning write onto the RAM port. Optionally, it sweeps every RAM entry to a fixed value after reset before accepting any requests. The read port of the RAM is not touched by this block.

## Interface
- DEPTH, default 2**$bits(lut_addr_t): number of RAM entries swept by the init sequence.
- INIT_VALUE, default 32'h0000_0000: word written to every entry during the init sweep.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 is granted this cycle.
- req0_addr  in  lut_addr_t  requester 0 write address.
- req0_data  in  word_t  requester 0 write data.
- req1_valid / req1_ready / req1_addr / req1_data: same as requester 0, for requester 1.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  lut_addr_t  to RAM wr_addr.
- ram_wr_data  out  word_t  to RAM wr_data.
- init_busy  out  1  init sweep in progress; no requests are accepted.
- last_grant  out  1  index of the most recently accepted requester.

## Operation
- FSM states: INIT and RUN. Reset enters INIT when the macro is defined, otherwise RUN.
- INIT:
  - Counter init_cnt starts at 0.
  - Each cycle drives ram_wr_en=1, ram_wr_addr=init_cnt and ram_wr_data=INIT_VALUE, then increments init_cnt.
  - After the cycle with init_cnt==DEPTH-1, the FSM moves to RUN.
  - req0_ready and req1_ready are held at 0.
- RUN, arbitration (combinational):
  - A round-robin pointer rr selects the preferred requester.
  - If only one requester is valid, it is granted.
  - If both are valid, requester rr is granted.
  - req_ready is asserted only for the granted requester and only when its valid is high.
- RUN, acceptance:
  - A request is accepted when valid&&ready.
  - Its addr and data are registered. ram_wr_en=1 with those values is driven in the next cycle.
  - rr then points to the other requester, and last_grant takes the accepted index.
  - With no acceptance, ram_wr_en=0 next cycle, and rr and last_grant hold.
- Throughput: one write per cycle, sustained. With both requesters continuously valid, grants alternate 0,1,0,1.
- Both requesters targeting the same address in one cycle: only the grantee is written. The other stays pending and is written on a later grant, so the last-accepted write wins.
- Registered ram_wr_addr and ram_wr_data hold their previous values when ram_wr_en=0.

## Timing
- Reset values:
  - ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0.
  - rr=0, last_grant=0.
  - init_cnt=0.
  - init_busy=1 with the macro defined, 0 without.
- ram_wr_en is 0 in every cycle where rst is high.
- Init sweep: the first cycle after rst falls writes address 0, and cycle k writes address k.
  - The FSM enters RUN in cycle DEPTH. init_busy falls in that same cycle, and req_ready may assert in it.
- Write latency: a request accepted in cycle N drives ram_wr_en in cycle N+1. The RAM holds the data after the rising edge that ends cycle N+1.
- Ready depends combinationally on the valids and on state. Requesters must not make valid depend on ready.
- Once asserted, valid, addr and data must stay stable until accepted.
- Reset mid-operation:
  - A registered but not-yet-driven write is discarded (ram_wr_en=0).
  - rr returns to 0.
  - The sweep restarts from address 0 if the macro is defined.

## Configuration
- LUT_RAM_WR_CTRL_INIT_EN
  - Defined: reset enters INIT, the DEPTH-cycle sweep writes INIT_VALUE to every entry, and init_busy is high during the sweep.
  - Undefined: INIT state and init_cnt are not compiled. Reset enters RUN directly, init_busy is tied 0, and requests can be accepted in the first cycle after rst falls.

## Test plan
- Init sweep (macro on, DEPTH=32):
  - Release rst, keep both valids high.
  - Expect ram_wr_en=1 for 32 cycles with addresses 0..31 and data 0, and both readies 0 throughout.
  - Expect init_busy to fall in cycle 32, with the first grant to requester 0 in that cycle.
- Single requester:
  - Only req1_valid=1 with addr=5, data=32'hDEAD_BEEF.
  - Expect req1_ready=1 the same cycle, then ram_wr_en=1, addr=5, data=32'hDEAD_BEEF the next cycle, and last_grant=1.
- Contention fairness:
  - Both valid for 6 cycles, req0 with addr=1 and req1 with addr=2.
  - Expect grants 0,1,0,1,0,1 and ram_wr_addr 1,2,1,2,1,2, each one cycle after its grant.
- Same-address collision:
  - Both valid to addr=7, req0 data=32'h1111_1111 and req1 data=32'h2222_2222, with rr=0.
  - Expect 32'h1111_1111 written first and 32'h2222_2222 the next cycle.
  - Expect a RAM read of addr 7 to return 32'h2222_2222 afterwards.
- Reset mid-operation:
  - Assert rst for 1 cycle directly after accepting a request to addr=9, data=32'hCAFE_F00D.
  - Expect no write to addr 9, ram_wr_en=0 during reset, and the sweep restarting at addr 0 (macro on).
- Macro off:
  - Request from req0 in the first cycle after rst falls.
  - Expect it accepted immediately, init_busy=0 always, and the write on the next cycle.
